pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Hazard/control unit for the 5-stage Y86-64 pipeline. Generates stall and bubble requests for the
//  F/D/E/M/W pipe registers from stage icodes, source/dest IDs, branch outcome and status codes.
//  Sequences start-up flush, exception drain and halt via an FSM and keeps saturating event counters.
//  Sits beside the datapath; decode consumes D_stall/E_bubble, the other stages consume the rest.
// PARAMETERS
//  FLUSH_CYCLES  4   cycles after reset release with all bubbles forced (pipe flush)
//  CNT_W         32  width of each event counter (saturating)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  D_icode    in   4      icode in decode
//  d_srcA     in   4      decode srcA (4'hF = none)
//  d_srcB     in   4      decode srcB (4'hF = none)
//  E_icode    in   4      icode in execute
//  E_dstM     in   4      execute dstM (4'hF = none)
//  e_Cnd      in   1      branch condition computed in execute
//  M_icode    in   4      icode in memory
//  m_stat     in   4      memory-stage status, one-hot: AOK=1000 HLT=0100 ADR=0010 INS=0001
//  W_stat     in   4      writeback status, same encoding
//  F_stall    out  1      hold fetch PC register
//  D_stall    out  1      hold D pipe register
//  D_bubble   out  1      load nop into D
//  E_bubble   out  1      load nop into E (icode 1, dstE/dstM 4'hF, stat AOK)
//  M_bubble   out  1      load nop into M (suppress memory write)
//  W_stall    out  1      hold W pipe register
//  halted     out  1      pipeline stopped on non-AOK W_stat
//  cpu_stat   out  4      latched terminating status; AOK while running
//  cyc_cnt    out  CNT_W  cycles spent in RUN
//  stall_cnt  out  CNT_W  RUN cycles with D_stall=1
//  bub_cnt    out  CNT_W  RUN cycles with E_bubble=1
// BEHAVIOUR
//  Icodes: JXX=7, MRMOV=5, POP=B, RET=9. lu = (E_icode in {5,B}) & E_dstM!=F & E_dstM in {d_srcA,d_srcB}.
//  ret = 9 in {D_icode,E_icode,M_icode}; mis = E_icode==7 & !e_Cnd; exc = m_stat!=AOK | W_stat!=AOK.
//  FSM states INIT, RUN, DRAIN, HALT. Reset: state=INIT, flush counter=0, halted=0, cpu_stat=AOK,
//  all counters 0. While rst_n low or in INIT: F_stall=1, D_bubble=E_bubble=M_bubble=1, D_stall=W_stall=0.
//  INIT -> RUN after exactly FLUSH_CYCLES clock edges following rst_n release.
//  RUN (combinational, same cycle as inputs):
//   F_stall=lu|ret; D_stall=lu; D_bubble=mis|(ret&!lu); E_bubble=mis|lu; M_bubble=exc; W_stall=W_stat!=AOK.
//   D_stall and D_bubble never both 1; lu takes precedence over ret bubble.
//  RUN -> DRAIN when m_stat!=AOK (W_stat still AOK): outputs as RUN plus F_stall=1, D_bubble=1, E_bubble=1.
//  RUN/DRAIN -> HALT when W_stat!=AOK: at that edge cpu_stat<=W_stat, halted<=1.
//  HALT: F_stall=1, W_stall=1, D_bubble=E_bubble=M_bubble=1, D_stall=0; absorbing until rst_n low.
//  Counters increment only in RUN, saturate at all-ones (no wrap); frozen in DRAIN/HALT.
//  rst_n low mid-operation: immediate return to reset values, no clock needed; in-flight status discarded.
//  Non-one-hot stat input treated as non-AOK (any value != 4'b1000).
// TESTING
//  Reset release, FLUSH_CYCLES=4 -> bubbles/F_stall high 4 cycles, then RUN with all outputs 0, cyc_cnt counts.
//  E_icode=5,E_dstM=3,d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt and bub_cnt +1.
//  E_icode=7,e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; e_Cnd=1 -> both 0.
//  RET walks D->E->M over 3 cycles -> F_stall=D_bubble=1 each cycle; with lu in same cycle -> D_stall=1, D_bubble=0.
//  m_stat=ADR then W_stat=ADR -> M_bubble, DRAIN, then halted=1, cpu_stat=0010, W_stall held, counters frozen.
//  CNT_W=4 force 20 RUN cycles -> cyc_cnt sticks at 15; rst_n pulse in HALT -> all reset values, INIT restarts.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stage information flowing from the Y86-64 datapath into the hazard/control
// unit, and the stall/bubble/status signals flowing back to the pipe registers.
// The datapath is the master. The control unit is the slave.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;
    logic [3:0]       cpu_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bub_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  halted, cpu_stat, cyc_cnt, stall_cnt, bub_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output halted, cpu_stat, cyc_cnt, stall_cnt, bub_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/control unit for the 5-stage Y86-64 pipeline.
// It detects load-use, ret and mispredict hazards and turns them into stall/bubble requests.
// A small FSM sequences the start-up flush, the exception drain and the halt.
// Saturating counters record the number of RUN cycles, the number of stalls and the number of bubbles.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave pif
);
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POP    = 4'hB;
    localparam int         FLUSH_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {INIT, RUN, DRAIN, HALT} state_t;

    state_t             state_q;
    logic [FLUSH_W-1:0] flushCnt_q;
    logic               halted_q;
    logic [3:0]         cpuStat_q;
    logic [CNT_W-1:0]   cycCnt_q, stallCnt_q, bubCnt_q;
    logic [CNT_W-1:0]   cycCnt_d, stallCnt_d, bubCnt_d;

    logic loadUse, retHazard, misPredict, mExc, wExc;
    logic fStall, dStall, dBubble, eBubble, mBubble, wStall;

    // Raw hazard and exception conditions decoded from the current stage contents.
    // Any stat value other than the one-hot AOK code counts as an exception.
    always_comb begin
        loadUse    = ((pif.E_icode == I_MRMOV) || (pif.E_icode == I_POP)) &&
                     (pif.E_dstM != REG_NONE) &&
                     ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
        retHazard  = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) || (pif.M_icode == I_RET);
        misPredict = (pif.E_icode == I_JXX) && !pif.e_Cnd;
        mExc       = (pif.m_stat != STAT_AOK);
        wExc       = (pif.W_stat != STAT_AOK);
    end

    // Per-state pipe register controls.
    // A load-use stall suppresses the ret bubble so that D is held, not overwritten.
    // DRAIN bubbles D, so it never also asks D to hold.
    always_comb begin
        fStall  = 1'b1;
        dStall  = 1'b0;
        dBubble = 1'b1;
        eBubble = 1'b1;
        mBubble = 1'b1;
        wStall  = 1'b0;
        case (state_q)
            INIT: ;
            RUN: begin
                fStall  = loadUse | retHazard;
                dStall  = loadUse;
                dBubble = misPredict | (retHazard & ~loadUse);
                eBubble = misPredict | loadUse;
                mBubble = mExc | wExc;
                wStall  = wExc;
            end
            DRAIN: begin
                mBubble = mExc | wExc;
                wStall  = wExc;
            end
            HALT: wStall = 1'b1;
            default: ;
        endcase
    end

    // Next values of the event counters; each counter sticks at all-ones rather than wrapping.
    always_comb begin
        cycCnt_d   = (cycCnt_q   == '1) ? cycCnt_q   : cycCnt_q   + 1'b1;
        stallCnt_d = (stallCnt_q == '1) ? stallCnt_q : stallCnt_q + 1'b1;
        bubCnt_d   = (bubCnt_q   == '1) ? bubCnt_q   : bubCnt_q   + 1'b1;
    end

    // Control FSM: flush after reset, run, drain on a memory exception, and latch the terminating status on halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            flushCnt_q <= '0;
            halted_q   <= 1'b0;
            cpuStat_q  <= STAT_AOK;
            cycCnt_q   <= '0;
            stallCnt_q <= '0;
            bubCnt_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (flushCnt_q == FLUSH_LAST) begin
                        state_q <= RUN;
                    end else begin
                        flushCnt_q <= flushCnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cycCnt_q <= cycCnt_d;
                    if (dStall) begin
                        stallCnt_q <= stallCnt_d;
                    end
                    if (eBubble) begin
                        bubCnt_q <= bubCnt_d;
                    end
                    if (wExc) begin
                        state_q   <= HALT;
                        halted_q  <= 1'b1;
                        cpuStat_q <= pif.W_stat;
                    end else if (mExc) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wExc) begin
                        state_q   <= HALT;
                        halted_q  <= 1'b1;
                        cpuStat_q <= pif.W_stat;
                    end
                end
                HALT: ;
                default: state_q <= INIT;
            endcase
        end
    end

    assign pif.F_stall   = fStall;
    assign pif.D_stall   = dStall;
    assign pif.D_bubble  = dBubble;
    assign pif.E_bubble  = eBubble;
    assign pif.M_bubble  = mBubble;
    assign pif.W_stall   = wStall;
    assign pif.halted    = halted_q;
    assign pif.cpu_stat  = cpuStat_q;
    assign pif.cyc_cnt   = cycCnt_q;
    assign pif.stall_cnt = stallCnt_q;
    assign pif.bub_cnt   = bubCnt_q;
endmodule
